// File: rtl/ram_scan_viewer_pkg.sv
// Shared types and default sizes for the RAM scan viewer.
package ram_scan_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [2:0] {INIT, IDLE, WRITE, RD, CAP} state_t;
endpackage

// File: rtl/ram_scan_viewer_spram.sv
// Inferred single-port RAM, read-first, registered output (1-cycle read latency).
module sync_spram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    r_q <= r_mem[i_addr];
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_q = r_q;
endmodule

// File: rtl/ram_scan_viewer.sv
// RAM front end: switch-driven writes, divided-rate scan/manual reads, held display pair.
// Optional RAM_CLEAR_EN: zero the whole RAM after every reset before going idle.
module ram_scan_viewer import ram_scan_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mode,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic              pause,
  output logic              busy,
  output logic              wr_done,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);
  localparam int                CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef RAM_CLEAR_EN
  localparam state_t RST_ST = INIT;
`else
  localparam state_t RST_ST = IDLE;
`endif

  logic              r_sync1, r_sync2, r_sync3, r_wr_edge;
  logic [ADDR_W-1:0] r_wr_addr, r_scan_addr, r_rd_addr, r_cap_addr, r_disp_addr;
  logic [DATA_W-1:0] r_wr_data, r_disp_data;
  logic              r_wr_pend, r_tick_pend, r_wr_done, r_disp_valid;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state;
`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] r_init_addr;
`endif

  logic              w_tick, w_wr_go, w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;

  // Synchroniser is left out of reset so a switch held high across reset
  // does not look like a fresh rising edge afterwards.
  always_ff @(posedge CLOCK_50) begin
    r_sync1 <= wr_req;
    r_sync2 <= r_sync1;
    r_sync3 <= r_sync2;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_wr_edge <= 1'b0;
    else       r_wr_edge <= r_sync2 & ~r_sync3;
  end

  assign w_tick  = (r_cnt == CNT_MAX);
  assign w_wr_go = r_wr_edge | r_wr_pend;

  always_ff @(posedge CLOCK_50) begin
    if (reset)                r_cnt <= '0;
`ifdef RAM_CLEAR_EN
    else if (r_state == INIT) r_cnt <= '0;
`endif
    else if (w_tick)          r_cnt <= '0;
    else                      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Read address is latched at the tick so a deferred read still uses the
  // address that was current when its tick fired.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_scan_addr <= '0;
      r_rd_addr   <= '0;
    end else if (w_tick) begin
      r_rd_addr <= mode ? man_addr : r_scan_addr;
      if (!mode && !pause)
        r_scan_addr <= (r_scan_addr == LAST_ADDR) ? '0 : r_scan_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= RST_ST;
      r_wr_pend    <= 1'b0;
      r_tick_pend  <= 1'b0;
      r_wr_done    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cap_addr   <= '0;
      r_disp_addr  <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
`ifdef RAM_CLEAR_EN
      r_init_addr  <= '0;
`endif
    end else begin
      r_wr_done <= 1'b0;
      if (r_wr_edge && r_state != INIT) begin
        r_wr_addr <= wr_addr;
        r_wr_data <= wr_data;
      end
      if (r_wr_edge && r_state != INIT && r_state != IDLE) r_wr_pend <= 1'b1;
      if (w_tick && (r_state != IDLE || w_wr_go))          r_tick_pend <= 1'b1;
      case (r_state)
`ifdef RAM_CLEAR_EN
        INIT: begin
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == LAST_ADDR) r_state <= IDLE;
        end
`endif
        IDLE: begin
          if (w_wr_go) r_state <= WRITE;
          else if (w_tick || r_tick_pend) begin
            r_state     <= RD;
            r_tick_pend <= 1'b0;
          end
        end
        WRITE: begin
          r_state   <= IDLE;
          r_wr_done <= 1'b1;
          if (!r_wr_edge) r_wr_pend <= 1'b0;
        end
        RD: begin
          r_state    <= CAP;
          r_cap_addr <= r_rd_addr;
        end
        CAP: begin
          r_state      <= IDLE;
          r_disp_addr  <= r_cap_addr;
          r_disp_data  <= w_ram_q;
          r_disp_valid <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_rd_addr;
    w_ram_wdata = r_wr_data;
    case (r_state)
      WRITE: begin
        w_ram_we   = ~reset;
        w_ram_addr = r_wr_addr;
      end
`ifdef RAM_CLEAR_EN
      INIT: begin
        w_ram_we    = ~reset;
        w_ram_addr  = r_init_addr;
        w_ram_wdata = '0;
      end
`endif
      default: ;
    endcase
  end

  sync_spram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .i_clk   (CLOCK_50),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  assign busy       = ~reset & (r_state != IDLE);
  assign wr_done    = r_wr_done;
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
endmodule
